pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 5, number of pipeline registers after issue; legal range 2..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter FLUSH_STAGES, default 2, number of youngest stages cleared by flush; legal range 1..STAGES.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  issuing instruction present.
REQ-007 SHALL have port in_ready  output  1  issuing instruction accepted this cycle.
REQ-008 SHALL have ports in_rs1, in_rs2, in_rd  input  ADDR_WIDTH  source and destination register addresses.
REQ-009 SHALL have port in_regW  input  1  instruction writes in_rd.
REQ-010 SHALL have port in_load  input  1  instruction is a load.
REQ-011 SHALL have port stage_ready_go  input  STAGES  per-stage "work done" flag; bit 0 is the youngest stage.
REQ-012 SHALL have port flush  input  1  discard the youngest FLUSH_STAGES stages.
REQ-013 SHALL have port stage_valid  output  STAGES  per-stage occupancy.
REQ-014 SHALL have port stage_advance  output  STAGES  stage i hands its contents onward this cycle.
REQ-015 SHALL have port hazard  output  1  RAW interlock is blocking issue.
REQ-016 SHALL have port stall_cnt  output  32  count of cycles with in_valid=1 and in_ready=0.

Function
REQ-017 SHALL compute allowin[i] = !stage_valid[i] | (stage_ready_go[i] & allowin[i+1]), with allowin[STAGES]=1, combinationally.
REQ-018 SHALL drive stage_advance[i] = stage_valid[i] & stage_ready_go[i] & allowin[i+1].
REQ-019 SHALL, on a stage_advance[i] edge for i<STAGES-1, set stage_valid[i+1] and copy rd/regW/load tags from stage i to stage i+1.
REQ-020 SHALL clear stage_valid[i] on an edge where stage i advances and stage i-1 does not advance into it; the last stage retires on its own advance.
REQ-021 SHALL drive in_ready = in_valid & allowin[0] & !hazard & !flush, and load stage 0 tags from in_* on an in_ready edge.
REQ-022 SHALL treat a tag as a producer only when stage_valid=1, regW=1 and rd!=0.
REQ-023 SHALL assert hazard when in_valid=1 and any producer matches in_rs1 or in_rs2 per REQ-030 or REQ-031.
REQ-024 SHALL, on flush, clear stage_valid[0..FLUSH_STAGES-1] at the next edge; the remaining stages advance normally, and any advance into stage FLUSH_STAGES from a flushed stage is discarded.
REQ-025 SHALL give flush priority over issue: in_ready=0 in the flush cycle.
REQ-026 SHALL increment stall_cnt by 1 per cycle with in_valid & !in_ready, wrapping from 0xFFFFFFFF to 0.
REQ-027 SHALL have one cycle of latency from issue to stage_valid[0]=1, with no combinational path from in_valid to stage_valid.

Reset
REQ-028 SHALL, on an edge with rst=0, clear all stage_valid bits, all tags and stall_cnt to 0, regardless of in-flight state.
REQ-029 SHALL force in_ready=0, stage_advance=0 and hazard=0 while rst=0.

Configuration
REQ-030 SHALL, with macro PIPE_CTRL_BYPASS_EN defined, restrict hazard to a load producer in stage 0 (load-use, one bubble); all other results are assumed forwarded.
REQ-031 SHALL, without PIPE_CTRL_BYPASS_EN, assert hazard for a producer in any stage 0..STAGES-1, including the writeback stage.

Verification
REQ-032 SHALL cover back-to-back issue: 6 independent instructions, all ready_go=1 -> in_ready=1 every cycle, stage_valid=5'b11111 after 5 cycles, stall_cnt=0.
REQ-033 SHALL cover a back-pressure bubble: stage_ready_go[2]=0 for 3 cycles with the pipe full -> stages 0..2 hold, stage 3 empties, in_ready=0 for 3 cycles, stall_cnt=3.
REQ-034 SHALL cover RAW without bypass: addi x5 issued, then an instruction with rs1=x5 -> hazard=1 for 5 cycles until x5 retires from stage 4; x0 as rd -> no hazard.
REQ-035 SHALL cover load-use with PIPE_CTRL_BYPASS_EN: a load to x7, then a use of x7 -> exactly 1 stall cycle; a non-load producer -> 0 stalls.
REQ-036 SHALL cover flush with issue: flush=1 and in_valid=1 with stages 0..4 valid -> in_ready=0, next cycle stage_valid[1:0]=0 and stages 2..4 progress.
REQ-037 SHALL cover reset mid-stream: rst=0 for one edge with the pipe full and stall_cnt=0xFFFFFFFF -> all outputs 0 next cycle; separately, a wrap from 0xFFFFFFFF -> 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline valid/allowin controller with RAW interlock, flush and issue-stall counter.
// Define PIPE_CTRL_BYPASS_EN to limit the interlock to load-use (all other results forwarded).
module pipe_ctrl #(
  parameter int STAGES       = 5,
  parameter int ADDR_WIDTH   = 5,
  parameter int FLUSH_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_regW,
  input  logic                  in_load,
  input  logic [STAGES-1:0]     stage_ready_go,
  input  logic                  flush,
  output logic [STAGES-1:0]     stage_valid,
  output logic [STAGES-1:0]     stage_advance,
  output logic                  hazard,
  output logic [31:0]           stall_cnt
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic                  reg_w;
    logic                  load;
  } tag_t;

  tag_t              tags [STAGES];
  logic [STAGES-1:0] adv_raw;
  logic              allow0;
  logic              match;

  // Walk from the oldest stage toward issue so each stage sees its successor's allowin.
  // NOTE: the loop carry relies on blocking assignments being visible to the next iteration.
  always_comb begin
    logic carry;
    adv_raw = '0;
    carry   = 1'b1;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv_raw[i] = stage_valid[i] & stage_ready_go[i] & carry;
      carry      = !stage_valid[i] | (stage_ready_go[i] & carry);
    end
    allow0 = carry;
  end

  always_comb begin
    match = 1'b0;
`ifdef PIPE_CTRL_BYPASS_EN
    if (stage_valid[0] && tags[0].reg_w && tags[0].load && tags[0].rd != '0 &&
        (tags[0].rd == in_rs1 || tags[0].rd == in_rs2))
      match = 1'b1;
`else
    for (int i = 0; i < STAGES; i++) begin
      if (stage_valid[i] && tags[i].reg_w && tags[i].rd != '0 &&
          (tags[i].rd == in_rs1 || tags[i].rd == in_rs2))
        match = 1'b1;
    end
`endif
  end

  assign hazard        = rst & in_valid & match;
  assign in_ready      = rst & in_valid & allow0 & !hazard & !flush;
  assign stage_advance = {STAGES{rst}} & adv_raw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_valid <= '0;
      stall_cnt   <= '0;
      // NOTE: the tag array sits in flops, so clearing it on reset is cheap and keeps state deterministic.
      for (int i = 0; i < STAGES; i++) tags[i] <= '0;
    end else begin
      if (in_valid && !in_ready) stall_cnt <= stall_cnt + 32'd1;

      if (flush) begin
        stage_valid[0] <= 1'b0;
      end else if (in_ready) begin
        stage_valid[0] <= 1'b1;
        tags[0]        <= '{rd: in_rd, reg_w: in_regW, load: in_load};
      end else if (stage_advance[0]) begin
        stage_valid[0] <= 1'b0;
      end

      // A flushed stage handing off into the first surviving stage must not land there.
      for (int i = 1; i < STAGES; i++) begin
        if (flush && i < FLUSH_STAGES) begin
          stage_valid[i] <= 1'b0;
        end else if (stage_advance[i-1] && !(flush && i == FLUSH_STAGES)) begin
          stage_valid[i] <= 1'b1;
          tags[i]        <= tags[i-1];
        end else if (stage_advance[i]) begin
          stage_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (default parameters).
// Inputs are driven and outputs sampled just after the falling edge.
module tb_pipe_ctrl;
  localparam int STAGES       = 5;
  localparam int ADDR_WIDTH   = 5;
  localparam int FLUSH_STAGES = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_rs1, in_rs2, in_rd;
  logic                  in_regW, in_load;
  logic [STAGES-1:0]     stage_ready_go;
  logic                  flush;
  logic [STAGES-1:0]     stage_valid;
  logic [STAGES-1:0]     stage_advance;
  logic                  hazard;
  logic [31:0]           stall_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_stall = '0;

  pipe_ctrl #(.STAGES(STAGES), .ADDR_WIDTH(ADDR_WIDTH), .FLUSH_STAGES(FLUSH_STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_regW(in_regW), .in_load(in_load),
    .stage_ready_go(stage_ready_go), .flush(flush), .stage_valid(stage_valid),
    .stage_advance(stage_advance), .hazard(hazard), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_regW = 1'b0; in_load = 1'b0; flush = 1'b0;
  endtask

  task automatic drive(input logic [ADDR_WIDTH-1:0] rs1, input logic [ADDR_WIDTH-1:0] rs2,
                       input logic [ADDR_WIDTH-1:0] rd, input logic regw, input logic load);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_regW = regw; in_load = load;
  endtask

  task automatic fill_pipe(input logic [ADDR_WIDTH-1:0] base);
    for (int k = 0; k < STAGES; k++) begin
      drive('0, '0, ADDR_WIDTH'(base + k), 1'b1, 1'b0);
      step();
    end
    idle();
  endtask

  task automatic drain();
    idle();
    repeat (STAGES) step();
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); stage_ready_go = '1;
    drive('0, '0, 5'd3, 1'b1, 1'b0);
    step(); #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", in_ready); else n_pass++;
    n_checks++; if (stage_advance !== '0) $display("FAIL reset_advance: got %b want 00000", stage_advance); else n_pass++;
    n_checks++; if (hazard !== 1'b0) $display("FAIL reset_hazard: got %0b want 0", hazard); else n_pass++;
    n_checks++; if (stage_valid !== '0) $display("FAIL reset_valid: got %b want 00000", stage_valid); else n_pass++;
    n_checks++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall: got %0d want 0", stall_cnt); else n_pass++;
    rst = 1'b1; idle();
    step();
  endtask

  task automatic test_back_to_back();
    logic [STAGES-1:0] exp_v;
    for (int k = 0; k <= STAGES; k++) begin
      exp_v = STAGES'((1 << k) - 1);
      n_checks++; if (stage_valid !== exp_v) $display("FAIL b2b_valid_%0d: got %b want %b", k, stage_valid, exp_v); else n_pass++;
      drive('0, '0, ADDR_WIDTH'(k + 1), 1'b1, 1'b0);
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %0b want 1", k, in_ready); else n_pass++;
      if (k == STAGES) begin
        n_checks++; if (stage_advance !== 5'b11111) $display("FAIL b2b_advance: got %b want 11111", stage_advance); else n_pass++;
      end
      step();
    end
    idle();
    n_checks++; if (stage_valid !== 5'b11111) $display("FAIL b2b_full: got %b want 11111", stage_valid); else n_pass++;
    n_checks++; if (stall_cnt !== exp_stall) $display("FAIL b2b_stall: got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
    drain();
    n_checks++; if (stage_valid !== '0) $display("FAIL b2b_drained: got %b want 00000", stage_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [STAGES-1:0] exp_v [3];
    exp_v[0] = 5'b10111; exp_v[1] = 5'b00111; exp_v[2] = 5'b00111;
    fill_pipe(5'd1);
    stage_ready_go = 5'b11011;
    drive('0, '0, 5'd9, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_%0d: got %0b want 0", c, in_ready); else n_pass++;
      if (c == 0) begin
        n_checks++; if (stage_advance !== 5'b11000) $display("FAIL bp_advance: got %b want 11000", stage_advance); else n_pass++;
      end
      step();
      n_checks++; if (stage_valid !== exp_v[c]) $display("FAIL bp_valid_%0d: got %b want %b", c, stage_valid, exp_v[c]); else n_pass++;
    end
    exp_stall += 32'd3;
    stage_ready_go = '1; idle();
    n_checks++; if (stall_cnt !== exp_stall) $display("FAIL bp_stall: got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
    drain();
  endtask

  task automatic test_raw();
    drive('0, '0, 5'd5, 1'b1, 1'b0);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL raw_issue: got %0b want 1", in_ready); else n_pass++;
    step();
    drive(5'd5, '0, 5'd6, 1'b1, 1'b0);
    for (int j = 0; j < STAGES; j++) begin
      #1;
      n_checks++; if (hazard !== 1'b1) $display("FAIL raw_hazard_%0d: got %0b want 1", j, hazard); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL raw_ready_%0d: got %0b want 0", j, in_ready); else n_pass++;
      step();
    end
    #1;
    n_checks++; if (hazard !== 1'b0) $display("FAIL raw_clear: got %0b want 0", hazard); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL raw_release: got %0b want 1", in_ready); else n_pass++;
    step();
    idle();
    exp_stall += 32'd5;
    n_checks++; if (stall_cnt !== exp_stall) $display("FAIL raw_stall: got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
    drain();
    drive('0, '0, '0, 1'b1, 1'b0);
    step();
    drive('0, '0, 5'd1, 1'b1, 1'b0);
    #1;
    n_checks++; if (hazard !== 1'b0) $display("FAIL raw_x0_hazard: got %0b want 0", hazard); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL raw_x0_ready: got %0b want 1", in_ready); else n_pass++;
    step();
    drain();
  endtask

  task automatic test_load_use();
    drive('0, '0, 5'd7, 1'b1, 1'b1);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL lu_issue: got %0b want 1", in_ready); else n_pass++;
    step();
    drive('0, 5'd7, 5'd8, 1'b1, 1'b0);
    #1;
    n_checks++; if (hazard !== 1'b1) $display("FAIL lu_hazard: got %0b want 1", hazard); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL lu_stall: got %0b want 0", in_ready); else n_pass++;
    step(); #1;
    n_checks++; if (hazard !== 1'b0) $display("FAIL lu_clear: got %0b want 0", hazard); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL lu_release: got %0b want 1", in_ready); else n_pass++;
    step();
    drive(5'd8, 5'd7, 5'd9, 1'b1, 1'b0);
    #1;
    n_checks++; if (hazard !== 1'b0) $display("FAIL lu_alu_fwd: got %0b want 0", hazard); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL lu_alu_ready: got %0b want 1", in_ready); else n_pass++;
    step();
    idle();
    exp_stall += 32'd1;
    n_checks++; if (stall_cnt !== exp_stall) $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
    drain();
  endtask

  task automatic test_flush();
    fill_pipe(5'd11);
    drive('0, '0, 5'd20, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_ready: got %0b want 0", in_ready); else n_pass++;
    n_checks++; if (stage_advance !== 5'b11111) $display("FAIL flush_advance: got %b want 11111", stage_advance); else n_pass++;
    step();
    exp_stall += 32'd1;
    flush = 1'b0;
    n_checks++; if (stage_valid !== 5'b11000) $display("FAIL flush_valid: got %b want 11000", stage_valid); else n_pass++;
`ifndef PIPE_CTRL_BYPASS_EN
    drive('0, 5'd13, 5'd21, 1'b1, 1'b0);
    #1;
    n_checks++; if (hazard !== 1'b1) $display("FAIL flush_kept_tag: got %0b want 1", hazard); else n_pass++;
    in_rs2 = 5'd14;
    #1;
    n_checks++; if (hazard !== 1'b0) $display("FAIL flush_dropped_tag: got %0b want 0", hazard); else n_pass++;
    in_rs2 = 5'd12;
    #1;
    n_checks++; if (hazard !== 1'b1) $display("FAIL flush_oldest_tag: got %0b want 1", hazard); else n_pass++;
`endif
    idle();
    step();
    n_checks++; if (stall_cnt !== exp_stall) $display("FAIL flush_stall: got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
    drain();
  endtask

  task automatic test_reset_midstream();
    fill_pipe(5'd1);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    rst = 1'b0;
    drive(5'd1, '0, 5'd2, 1'b1, 1'b0);
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL mid_rst_ready: got %0b want 0", in_ready); else n_pass++;
    n_checks++; if (hazard !== 1'b0) $display("FAIL mid_rst_hazard: got %0b want 0", hazard); else n_pass++;
    n_checks++; if (stage_advance !== '0) $display("FAIL mid_rst_advance: got %b want 00000", stage_advance); else n_pass++;
    step();
    rst = 1'b1; idle();
    #1;
    n_checks++; if (stage_valid !== '0) $display("FAIL mid_rst_valid: got %b want 00000", stage_valid); else n_pass++;
    n_checks++; if (stall_cnt !== 32'd0) $display("FAIL mid_rst_stall: got %0d want 0", stall_cnt); else n_pass++;
    exp_stall = '0;
    step();
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    drive('0, '0, 5'd3, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL wrap_ready: got %0b want 0", in_ready); else n_pass++;
    step();
    idle();
    n_checks++; if (stall_cnt !== 32'd0) $display("FAIL wrap_stall: got %h want 00000000", stall_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
`ifdef PIPE_CTRL_BYPASS_EN
    test_load_use();
`else
    test_raw();
`endif
    test_flush();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
